// File: rtl/fp_accumulator_if.sv
// ---------------------------------------------------------------------------
// fp_accumulator_if
// Handshake bundle between the float multiplier, the accumulator and the
// activation stage.
//   start     : pulse that clears the accumulator and opens a new N-term sum
//   in_valid  : product valid (producer -> accumulator)
//   in_ready  : accumulator can take a product this cycle
//   product   : float operand {sign, exp[7:0], mant[22:0]}
//   out_valid : sum valid, held until consumed
//   out_ready : activation stage accepts the sum
//   sum       : accumulated float
// master = producer/consumer side, slave = accumulator.
// ---------------------------------------------------------------------------
interface fp_accumulator_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] product;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;

    modport master (
        output start, in_valid, product, out_ready,
        input  in_ready, out_valid, sum
    );

    modport slave (
        input  start, in_valid, product, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/fp_accumulator.sv
// ---------------------------------------------------------------------------
// fp_accumulator
// Sequential single-precision accumulator: sums N products into one float.
// No denormals, no Inf/NaN, truncation only, zero is 32'b0.
// One product is processed per 4 cycles (WAIT, ALIGN, ADD, NORM).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fp_accumulator_if.slave (start, product in, sum out handshakes)
// ---------------------------------------------------------------------------
module fp_accumulator #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_accumulator_if.slave     bus
);

    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_in_ready;
    logic               w_out_valid;

    logic [31:0]        r_acc;
    logic [31:0]        r_sum;
    logic [31:0]        r_prod;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_inc;

    logic [23:0]        r_sig_a_p0;
    logic [23:0]        r_sig_b_p0;
    logic [7:0]         r_exp_p0;
    logic               r_sign_a_p0;
    logic               r_sign_b_p0;

    logic [24:0]        r_mag_p1;
    logic [7:0]         r_exp_p1;
    logic               r_sign_p1;

    // Right shift with everything beyond 24 positions collapsing to zero.
    function automatic logic [23:0] f_align(input logic [23:0] sig, input logic [7:0] diff);
        if (diff >= 8'd25) return 24'd0;
        return sig >> diff;
    endfunction

    // Leading zeros of a 24-bit significand; 24 when the value is zero.
    function automatic logic [4:0] f_lzc(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Final packing: flush underflow / zero, saturate overflow.
    function automatic logic [31:0] f_pack(input logic sign, input logic signed [9:0] exp,
                                           input logic [22:0] mant, input logic is_zero);
        if (is_zero || exp <= 10'sd0) return 32'd0;
        if (exp > 10'sd254)           return {sign, 8'hFE, 23'h7FFFFF};
        return {sign, exp[7:0], mant};
    endfunction

    // ---------------- ALIGN: unpack acc and product, shift the smaller one
    logic        w_zero_a, w_zero_b, w_a_big;
    logic [23:0] w_sig_a, w_sig_b, w_shift_sig;
    logic [7:0]  w_exp_a, w_exp_b, w_exp_diff;

    always_comb begin
        w_zero_a    = (r_acc[30:0] == 31'd0);
        w_zero_b    = (r_prod[30:0] == 31'd0);
        w_sig_a     = w_zero_a ? 24'd0 : {1'b1, r_acc[22:0]};
        w_sig_b     = w_zero_b ? 24'd0 : {1'b1, r_prod[22:0]};
        w_exp_a     = r_acc[30:23];
        w_exp_b     = r_prod[30:23];
        w_a_big     = (w_exp_a >= w_exp_b);
        w_exp_diff  = w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
        w_shift_sig = f_align(w_a_big ? w_sig_b : w_sig_a, w_exp_diff);
    end

    // ---------------- ADD: signed-magnitude add/subtract on aligned significands
    logic [24:0] w_mag;
    logic        w_sign;

    always_comb begin
        w_mag  = 25'd0;
        w_sign = r_sign_a_p0;
        if (r_sign_a_p0 == r_sign_b_p0) begin
            w_mag = {1'b0, r_sig_a_p0} + {1'b0, r_sig_b_p0};
        end else if (r_sig_a_p0 >= r_sig_b_p0) begin
            w_mag = {1'b0, r_sig_a_p0} - {1'b0, r_sig_b_p0};
        end else begin
            w_mag  = {1'b0, r_sig_b_p0} - {1'b0, r_sig_a_p0};
            w_sign = r_sign_b_p0;
        end
    end

    // ---------------- NORM: carry shifts right, otherwise shift out leading zeros
    logic [4:0]         w_lzc;
    logic signed [9:0]  w_exp_n;
    logic [22:0]        w_mant;
    logic [31:0]        w_norm;

    always_comb begin
        w_lzc = f_lzc(r_mag_p1[23:0]);
        if (r_mag_p1[24]) begin
            w_exp_n = signed'({2'b00, r_exp_p1}) + 10'sd1;
            w_mant  = r_mag_p1[23:1];
        end else begin
            w_exp_n = signed'({2'b00, r_exp_p1}) - signed'({5'b00000, w_lzc});
            // The hidden bit lands on bit 23 after the shift and is dropped.
            w_mant  = r_mag_p1[22:0] << w_lzc;
        end
        w_norm = f_pack(r_sign_p1, w_exp_n, w_mant, (r_mag_p1 == 25'd0));
    end

    assign w_count_inc = r_count + CNT_W'(1);

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_WAIT;
            S_WAIT: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_next = S_ALIGN;
            end
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  w_next = (w_count_inc == CNT_W'(N)) ? S_DONE : S_WAIT;
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_acc   <= 32'd0;
            r_sum   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_acc   <= 32'd0;
                r_count <= '0;
            end
            if (r_state == S_NORM) begin
                r_acc   <= w_norm;
                r_count <= w_count_inc;
                if (w_next == S_DONE) r_sum <= w_norm;
            end
        end
    end

    // Datapath registers only carry values between states; they need no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_WAIT && bus.in_valid) r_prod <= bus.product;
        if (r_state == S_ALIGN) begin
            r_sig_a_p0  <= w_a_big ? w_sig_a : w_shift_sig;
            r_sig_b_p0  <= w_a_big ? w_shift_sig : w_sig_b;
            r_exp_p0    <= w_a_big ? w_exp_a : w_exp_b;
            r_sign_a_p0 <= r_acc[31];
            r_sign_b_p0 <= r_prod[31];
        end
        if (r_state == S_ADD) begin
            r_mag_p1  <= w_mag;
            r_exp_p1  <= r_exp_p0;
            r_sign_p1 <= w_sign;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.sum       = r_sum;

endmodule

// File: tb/tb_fp_accumulator.sv
module tb_fp_accumulator;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    int          lat     = 0;
    int          c_prev  = 0;
    logic [31:0] res;

    fp_accumulator_if bus ();
    fp_accumulator_if bus1 ();

    fp_accumulator #(.N(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    fp_accumulator #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Present p with in_valid high until in_ready is seen; returns one
    // negedge after the accepting edge, leaving in_valid as it is.
    task automatic feed(input logic [31:0] p);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.product  = p;
        while (!bus.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("feed_ready", {31'd0, bus.in_ready}, 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
    endtask

    // Wait for out_valid, optionally stall hold cycles (pulsing start once),
    // then handshake with start driven to hs_start.
    task automatic collect(input int hold, input logic hs_start, output logic [31:0] s);
        int t = 1;
        logic [31:0] s0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        lat = t;
        s0  = bus.sum;
        for (int i = 0; i < hold; i++) begin
            bus.start = (i == 1);
            @(negedge clk);
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_sum", bus.sum, s0);
        end
        bus.start     = hs_start;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
        s = s0;
    endtask

    task automatic do_sum(input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3,
                          input int hold, input logic hs_start, output logic [31:0] s);
        start_pulse();
        feed(p0);
        feed(p1);
        feed(p2);
        feed(p3);
        bus.in_valid = 1'b0;
        collect(hold, hs_start, s);
    endtask

    task automatic n1_sum(input logic [31:0] p, output logic [31:0] s);
        int t = 0;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start    = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.product  = p;
        while (!bus1.in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
        t = 0;
        while (!bus1.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("n1_out_valid", {31'd0, bus1.out_valid}, 32'd1);
        s = bus1.sum;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;  bus.in_valid = 1'b0;  bus.product = 32'd0;  bus.out_ready = 1'b0;
        bus1.start = 1'b0; bus1.in_valid = 1'b0; bus1.product = 32'd0; bus1.out_ready = 1'b0;

        #3;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_sum", bus.sum, 32'h00000000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic sum with in_valid held high across all four products
        start_pulse();
        feed(32'h3F800000);
        feed(32'h40000000);
        c_prev = acc_cyc;
        feed(32'h3F000000);
        check("in_ready_period", acc_cyc - c_prev, 32'd4);
        feed(32'h3E800000);
        bus.in_valid = 1'b0;
        collect(0, 1'b0, res);
        check("basic_latency", lat, 32'd4);
        check("basic_sum", res, 32'h40700000);

        do_sum(32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h80000000, 0, 1'b0, res);
        check("cancel_zero", res, 32'h00000000);

        do_sum(32'h40400000, 32'hBF800000, 32'h00000000, 32'h00000000, 0, 1'b0, res);
        check("cancel_left_norm", res, 32'h40000000);

        // Backpressure: 6 stalled cycles, start pulsed in DONE and at the handshake
        do_sum(32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000, 6, 1'b1, res);
        check("backpressure_sum", res, 32'h40800000);

        // Large gap, with start held high through WAIT/ALIGN/ADD/NORM of product 2
        start_pulse();
        feed(32'h4E800000);
        bus.start = 1'b1;
        feed(32'h3F800000);
        bus.start = 1'b0;
        feed(32'h00000000);
        feed(32'h00000000);
        bus.in_valid = 1'b0;
        collect(0, 1'b0, res);
        check("gap_2p30", res, 32'h4E800000);

        do_sum(32'h3F800000, 32'h33800000, 32'h00000000, 32'h00000000, 0, 1'b0, res);
        check("gap_2m24", res, 32'h3F800000);

        do_sum(32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000, 0, 1'b0, res);
        check("overflow_sat", res, 32'h7F7FFFFF);

        // Asynchronous reset in the middle of a sum
        start_pulse();
        feed(32'h3F800000);
        feed(32'h3F800000);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_sum", bus.sum, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_sum(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 1'b0, res);
        check("after_rst_sum", res, 32'h40800000);

        n1_sum(32'h40400000, res);
        check("n1_passthrough", res, 32'h40400000);
        n1_sum(32'h80000000, res);
        check("n1_neg_zero", res, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
